// File: rtl/ga_pkg.sv
// Shared constants and the FSM state type for the genetic-algorithm core.
// Contains only constants and types so that any stage can import it.
package ga_pkg;

    localparam int POP_SIZE  = 300;
    localparam int GENE_BITS = 25;
    localparam int POP_BITS  = POP_SIZE * GENE_BITS;

    // Width of a bit index inside one individual
    localparam int IDX_W = $clog2(GENE_BITS);
    // Width of the individual index (0..POP_SIZE-1)
    localparam int IND_W = $clog2(POP_SIZE);
    // Width of the mutation count (0..POP_SIZE inclusive)
    localparam int CNT_W = $clog2(POP_SIZE + 1);
    // Width of the mutation-rate threshold (0..256 inclusive)
    localparam int RATE_W = 9;

    localparam int                LFSR_W    = 32;
    // Galois feedback for x^32 + x^22 + x^2 + x + 1
    localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ga_lfsr.sv
// 32-bit right-shifting Galois LFSR with a load-on-reset seed.
// Advances only when en is high; otherwise holds its value.
module ga_lfsr
    import ga_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    // Shift right; when the bit shifted out is 1, fold in the feedback mask
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= SEED;
        end else if (en) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
        end
    end

endmodule

// File: rtl/ga_mutate.sv
// Mutation stage: captures a population, walks it one individual per
// cycle by rotating a working register, and flips at most one
// LFSR-chosen bit per individual with probability MUT_RATE/256.
module ga_mutate
    import ga_pkg::*;
#(
    parameter logic [RATE_W-1:0] MUT_RATE = 9'd8,
    parameter logic [LFSR_W-1:0] SEED     = 32'hACE1_2024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mut_start,
    input  logic [POP_BITS-1:0] population,
    output logic [POP_BITS-1:0] mut_pop,
    output logic                mut_done,
    output logic [CNT_W-1:0]    mut_count
);

    localparam logic [IND_W-1:0] IND_LAST   = IND_W'(POP_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(POP_SIZE);
    localparam logic [IDX_W-1:0] GENE_LIMIT = IDX_W'(GENE_BITS);

    state_t state_reg;
    state_t state_next;

    logic [POP_BITS-1:0]  work_reg;
    logic [IND_W-1:0]     idx_reg;
    logic [CNT_W-1:0]     count_reg;

    logic                 load_en;
    logic                 run_en;
    logic                 done_entry;

    logic [LFSR_W-1:0]    lfsr_q;
    logic                 mutate;
    logic [IDX_W-1:0]     bit_raw;
    logic [IDX_W-1:0]     bit_idx;
    logic [GENE_BITS-1:0] flip_mask;
    logic [GENE_BITS-1:0] slice_next;
    logic [POP_BITS-1:0]  work_next;
    logic [CNT_W-1:0]     count_next;
    logic                 unused_lfsr;

    // The random source only steps while an individual is being processed
    ga_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (run_en),
        .q     (lfsr_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; mut_start is only looked at in IDLE and DONE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (mut_start) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (idx_reg == IND_LAST) state_next = DONE;
            DONE: if (!mut_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded controls and the completion level
    always_comb begin
        load_en    = (state_reg == LOAD);
        run_en     = (state_reg == RUN);
        done_entry = (state_reg == RUN) && (idx_reg == IND_LAST);
        mut_done   = (state_reg == DONE);
    end

    // Mutation decision and bit choice from the pre-advance LFSR value;
    // a 5-bit raw index can reach 31, so one subtraction folds it into 0..24
    always_comb begin
        mutate     = ({1'b0, lfsr_q[7:0]} < MUT_RATE);
        bit_raw    = lfsr_q[8 +: IDX_W];
        bit_idx    = (bit_raw >= GENE_LIMIT) ? (bit_raw - GENE_LIMIT) : bit_raw;
        count_next = count_reg + CNT_W'(mutate && (count_reg != CNT_MAX));
    end

    // One-hot flip mask, empty when this individual is not mutated
    generate
        for (genvar gi = 0; gi < GENE_BITS; gi++) begin : g_flip
            assign flip_mask[gi] = mutate && (bit_idx == IDX_W'(gi));
        end
    endgenerate

    assign slice_next = work_reg[GENE_BITS-1:0] ^ flip_mask;
    // Rotate right by one individual: the processed slice moves to the top
    assign work_next  = {slice_next, work_reg[POP_BITS-1:GENE_BITS]};

    assign unused_lfsr = ^lfsr_q[LFSR_W-1:8+IDX_W];

    // Working register, walk index, running count and published result
    always_ff @(posedge clk) begin
        if (reset) begin
            work_reg  <= '0;
            idx_reg   <= '0;
            count_reg <= '0;
            mut_pop   <= '0;
            mut_count <= '0;
        end else if (load_en) begin
            work_reg  <= population;
            idx_reg   <= '0;
            count_reg <= '0;
        end else if (run_en) begin
            work_reg  <= work_next;
            idx_reg   <= idx_reg + 1'b1;
            count_reg <= count_next;
            if (done_entry) begin
                mut_pop   <= work_next;
                mut_count <= count_next;
            end
        end
    end

endmodule
